// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch driven by rising edges of the 1 Hz LEDG wave, with four active-low 7-segment outputs.
// Optional macro LAP_EN adds a lap/freeze of the displayed value.
module stopwatch_bcd #(
    parameter int TICKS_PER_SEC = 1,
    parameter int ROLL_MINUTES  = 60
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       LEDG,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic       running,
    output logic       rollover
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    localparam logic [3:0] PRE_LAST      = 4'(TICKS_PER_SEC - 1);
    localparam logic [3:0] MIN_LAST_TENS = 4'((ROLL_MINUTES - 1) / 10);
    localparam logic [3:0] MIN_LAST_ONES = 4'((ROLL_MINUTES - 1) % 10);
    localparam logic [6:0] SEG_ZERO      = 7'b1000000;

    state_t     state;
    logic       ledg_q;
    logic       armed;
    logic [3:0] prescaler;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       rise, tick, min_wrap, wrap, show_live;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // armed keeps a LEDG level that is already high at reset release from counting as an edge
    assign rise     = armed & LEDG & ~ledg_q;
    assign tick     = (state == RUN) & rise & (prescaler == PRE_LAST);
    assign min_wrap = (min_tens == MIN_LAST_TENS) & (min_ones == MIN_LAST_ONES);
    assign wrap     = tick & (sec_ones == 4'd9) & (sec_tens == 4'd5) & min_wrap;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            ledg_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            ledg_q <= LEDG;
            armed  <= 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            running <= 1'b0;
        end else if (clear) begin
            state   <= IDLE;
            running <= 1'b0;
        end else if (start_stop) begin
            case (state)
                RUN: begin
                    state   <= PAUSE;
                    running <= 1'b0;
                end
                default: begin
                    state   <= RUN;
                    running <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            prescaler <= 4'd0;
        end else if (clear) begin
            prescaler <= 4'd0;
        end else if ((state == RUN) && rise) begin
            prescaler <= (prescaler == PRE_LAST) ? 4'd0 : prescaler + 4'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
            rollover <= 1'b0;
        end else begin
            rollover <= wrap & ~clear;
            if (clear) begin
                sec_ones <= 4'd0;
                sec_tens <= 4'd0;
                min_ones <= 4'd0;
                min_tens <= 4'd0;
            end else if (tick) begin
                if (sec_ones == 4'd9) begin
                    sec_ones <= 4'd0;
                    if (sec_tens == 4'd5) begin
                        sec_tens <= 4'd0;
                        if (min_wrap) begin
                            min_ones <= 4'd0;
                            min_tens <= 4'd0;
                        end else if (min_ones == 4'd9) begin
                            min_ones <= 4'd0;
                            min_tens <= min_tens + 4'd1;
                        end else begin
                            min_ones <= min_ones + 4'd1;
                        end
                    end else begin
                        sec_tens <= sec_tens + 4'd1;
                    end
                end else begin
                    sec_ones <= sec_ones + 4'd1;
                end
            end
        end
    end

`ifdef LAP_EN
    logic frozen;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            frozen <= 1'b0;
        end else if (clear) begin
            frozen <= 1'b0;
        end else if (lap && (state == RUN)) begin
            frozen <= ~frozen;
        end
    end

    assign show_live = ~frozen;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign show_live  = 1'b1;
`endif

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            HEX0 <= SEG_ZERO;
            HEX1 <= SEG_ZERO;
            HEX2 <= SEG_ZERO;
            HEX3 <= SEG_ZERO;
        end else if (show_live) begin
            HEX0 <= seg7(sec_ones);
            HEX1 <= seg7(sec_tens);
            HEX2 <= seg7(min_ones);
            HEX3 <= seg7(min_tens);
        end
    end

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed self-checking bench for stopwatch_bcd: vector table plus hand-written corner sequences.
module tb_stopwatch_bcd;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N;
    logic       LEDG;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;
    logic       running;
    logic       rollover;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       ss;
        logic       clr;
        int         rises;
        logic [3:0] mt, mo, st, so;
        logic       run;
        string      name;
    } vec_t;

    vec_t       vecs[11];
    logic [6:0] seg_lut[10];

    stopwatch_bcd dut (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .LEDG      (LEDG),
        .start_stop(start_stop),
        .clear     (clear),
        .lap       (lap),
        .HEX0      (HEX0),
        .HEX1      (HEX1),
        .HEX2      (HEX2),
        .HEX3      (HEX3),
        .running   (running),
        .rollover  (rollover)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic cycle();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic doRise();
        LEDG = 1'b1;
        cycle();
        LEDG = 1'b0;
        cycle();
    endtask

    task automatic checkVal(input string name, input logic [6:0] actual, input logic [6:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name, input logic [3:0] mt, input logic [3:0] mo,
                               input logic [3:0] st, input logic [3:0] so, input logic run);
        checkVal({name, ".HEX3"}, HEX3, seg_lut[mt]);
        checkVal({name, ".HEX2"}, HEX2, seg_lut[mo]);
        checkVal({name, ".HEX1"}, HEX1, seg_lut[st]);
        checkVal({name, ".HEX0"}, HEX0, seg_lut[so]);
        checkVal({name, ".running"}, {6'd0, running}, {6'd0, run});
    endtask

    task automatic applyStimulus(input vec_t v);
        start_stop = v.ss;
        clear      = v.clr;
        cycle();
        start_stop = 1'b0;
        clear      = 1'b0;
        for (int r = 0; r < v.rises; r++) doRise();
        cycle();
        cycle();
    endtask

    initial begin
        seg_lut[0] = 7'b1000000; seg_lut[1] = 7'b1111001; seg_lut[2] = 7'b0100100;
        seg_lut[3] = 7'b0110000; seg_lut[4] = 7'b0011001; seg_lut[5] = 7'b0010010;
        seg_lut[6] = 7'b0000010; seg_lut[7] = 7'b1111000; seg_lut[8] = 7'b0000000;
        seg_lut[9] = 7'b0010000;

        vecs[0]  = '{1'b0, 1'b0, 0,  4'd0, 4'd0, 4'd0, 4'd0, 1'b0, "idle_after_reset"};
        vecs[1]  = '{1'b1, 1'b0, 3,  4'd0, 4'd0, 4'd0, 4'd3, 1'b1, "start_3_rises"};
        vecs[2]  = '{1'b0, 1'b0, 2,  4'd0, 4'd0, 4'd0, 4'd5, 1'b1, "run_to_05"};
        vecs[3]  = '{1'b1, 1'b0, 4,  4'd0, 4'd0, 4'd0, 4'd5, 1'b0, "pause_ignores_rises"};
        vecs[4]  = '{1'b1, 1'b0, 1,  4'd0, 4'd0, 4'd0, 4'd6, 1'b1, "resume_to_06"};
        vecs[5]  = '{1'b0, 1'b0, 6,  4'd0, 4'd0, 4'd1, 4'd2, 1'b1, "run_to_12"};
        vecs[6]  = '{1'b1, 1'b1, 0,  4'd0, 4'd0, 4'd0, 4'd0, 1'b0, "clear_beats_start"};
        vecs[7]  = '{1'b0, 1'b0, 3,  4'd0, 4'd0, 4'd0, 4'd0, 1'b0, "idle_ignores_rises"};
        vecs[8]  = '{1'b1, 1'b0, 10, 4'd0, 4'd0, 4'd1, 4'd0, 1'b1, "sec_carry_10"};
        vecs[9]  = '{1'b0, 1'b0, 50, 4'd0, 4'd1, 4'd0, 4'd0, 1'b1, "min_carry_0100"};
        vecs[10] = '{1'b0, 1'b1, 0,  4'd0, 4'd0, 4'd0, 4'd0, 1'b0, "clear_in_run"};

        RESET_N = 1'b0; LEDG = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        cycle();
        cycle();
        RESET_N = 1'b1;
        cycle();
        cycle();
        cycle();
        LEDG = 1'b0;
        cycle();

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i].name, vecs[i].mt, vecs[i].mo, vecs[i].st, vecs[i].so, vecs[i].run);
        end

        // third rise: digit changes on edge E, display follows on E+1
        start_stop = 1'b1;
        cycle();
        start_stop = 1'b0;
        checkVal("running_after_start", {6'd0, running}, 7'd1);
        doRise();
        doRise();
        LEDG = 1'b1;
        cycle();
        checkVal("hex0_at_edge_E", HEX0, seg_lut[2]);
        LEDG = 1'b0;
        cycle();
        checkVal("hex0_at_edge_E1", HEX0, seg_lut[3]);

        LEDG = 1'b1; start_stop = 1'b1;
        cycle();
        LEDG = 1'b0; start_stop = 1'b0;
        cycle();
        cycle();
        checkOutput("tick_with_stop", 4'd0, 4'd0, 4'd0, 4'd4, 1'b0);
        doRise();
        checkOutput("paused_holds_04", 4'd0, 4'd0, 4'd0, 4'd4, 1'b0);

        start_stop = 1'b1;
        cycle();
        start_stop = 1'b0;
        LEDG = 1'b1; clear = 1'b1;
        cycle();
        LEDG = 1'b0; clear = 1'b0;
        cycle();
        cycle();
        checkOutput("tick_with_clear", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);

        start_stop = 1'b1;
        cycle();
        start_stop = 1'b0;
        for (int r = 0; r < 3598; r++) doRise();
        checkOutput("preload_5958", 4'd5, 4'd9, 4'd5, 4'd8, 1'b1);
        checkVal("no_rollover_early", {6'd0, rollover}, 7'd0);
        doRise();
        checkOutput("at_5959", 4'd5, 4'd9, 4'd5, 4'd9, 1'b1);
        LEDG = 1'b1;
        cycle();
        checkVal("rollover_pulse", {6'd0, rollover}, 7'd1);
        LEDG = 1'b0;
        cycle();
        checkVal("rollover_one_cycle", {6'd0, rollover}, 7'd0);
        checkOutput("wrapped_0000", 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        doRise();
        checkOutput("after_wrap_0001", 4'd0, 4'd0, 4'd0, 4'd1, 1'b1);

        #3;
        RESET_N = 1'b0;
        #1;
        checkOutput("async_reset", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        cycle();
        RESET_N = 1'b1;
        cycle();
        start_stop = 1'b1;
        cycle();
        start_stop = 1'b0;
        doRise();
        checkOutput("restart_after_reset", 4'd0, 4'd0, 4'd0, 4'd1, 1'b1);

`ifdef LAP_EN
        for (int r = 0; r < 6; r++) doRise();
        checkOutput("lap_pre_07", 4'd0, 4'd0, 4'd0, 4'd7, 1'b1);
        lap = 1'b1;
        cycle();
        lap = 1'b0;
        for (int r = 0; r < 5; r++) doRise();
        checkOutput("lap_frozen_07", 4'd0, 4'd0, 4'd0, 4'd7, 1'b1);
        lap = 1'b1;
        cycle();
        lap = 1'b0;
        cycle();
        cycle();
        checkOutput("lap_release_12", 4'd0, 4'd0, 4'd1, 4'd2, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_bcd.md
Name: stopwatch_bcd

Overview:
- Downstream consumer of the 1 Hz square wave from the clock-divider stage.
- Detects each rising edge of that wave and uses it as a seconds tick.
- Runs an MM:SS BCD stopwatch with start/stop and clear control.
- Drives four active-low 7-segment digits, plus run and rollover status.

Parameters:
TICKS_PER_SEC, 1, rising edges of LEDG per one-second increment (1..15; >1 only for slower divider setups).
ROLL_MINUTES, 60, minute count wraps to 0 after ROLL_MINUTES-1 (1..60).

Ports:
CLOCK_50  input  1  system clock, 50 MHz.
RESET_N  input  1  asynchronous, active-low reset.
LEDG  input  1  1 Hz square wave from the divider, synchronous to CLOCK_50.
start_stop  input  1  single-cycle pulse, already debounced; toggles run/pause.
clear  input  1  single-cycle pulse; zeroes count and returns to IDLE.
lap  input  1  single-cycle pulse; only used when LAP_EN is defined.
HEX0  output  7  seconds ones, active-low, bit6=g .. bit0=a.
HEX1  output  7  seconds tens.
HEX2  output  7  minutes ones.
HEX3  output  7  minutes tens.
running  output  1  high while in RUN.
rollover  output  1  one-cycle pulse on wrap from (ROLL_MINUTES-1):59 to 00:00.

Behaviour:
- Reset (async assert, sync release) sets:
  - state IDLE; all BCD digits 0; prescaler 0.
  - ledg_q 0, armed 0.
  - HEX0..HEX3 = 7'b1000000 ("0"); running 0; rollover 0.
- Edge detect: ledg_q <= LEDG every cycle. armed <= 1 on the first clock after reset.
  - rise = armed & LEDG & ~ledg_q.
  - LEDG already high at reset release produces no rise.
- Prescaler: 4-bit counter of rises, active only in RUN. tick = rise when prescaler == TICKS_PER_SEC-1; the prescaler then returns to 0.
- FSM states and transitions:
  - IDLE: start_stop -> RUN.
  - RUN: start_stop -> PAUSE.
  - PAUSE: start_stop -> RUN.
  - clear from any state -> IDLE; digits zeroed, prescaler zeroed.
  - Priority: clear > start_stop. If both are asserted in the same cycle, start_stop is ignored.
- Count update on tick in RUN:
  - sec_ones 0..9; carry into sec_tens 0..5.
  - carry into min_ones 0..9; carry into min_tens.
  - Minutes wrap to 00 after ROLL_MINUTES-1.
  - BCD digits never hold values >9 (tens digits never >5).
- Simultaneous events:
  - tick with start_stop in RUN: the increment happens, then PAUSE.
  - tick with clear: clear wins and the count becomes 00:00.
  - rises in IDLE/PAUSE are ignored; prescaler holds (PAUSE) or stays 0 (IDLE).
- Latency:
  - Digits update on the clock edge where LEDG is first sampled 1 (edge E).
  - HEX outputs are registered and reflect the new value at edge E+1.
  - running follows state with one cycle of latency (registered from next-state).
- rollover: registered, high for exactly the one cycle after the wrapping tick edge.
- Decoder, active-low, digits 0-9:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other code = 1111111 (blank; unreachable).
- Reset mid-operation: immediate return to the reset values; the next start begins at 00:00.

Optional Feature:
- Macro LAP_EN.
- Defined:
  - A lap pulse in RUN freezes the HEX outputs at the current count; counting continues internally.
  - A second lap pulse releases the freeze; the display resumes live values next cycle.
  - clear or reset also releases the freeze.
  - lap in IDLE/PAUSE is ignored.
- Not defined: the lap port is unused and the display always tracks the count.

Test Plan:
- Reset with LEDG=1 held, release -> no increment; HEX0..3=1000000; running=0.
- start_stop pulse, then 3 LEDG rises -> HEX0=0110000 ("3") one cycle after the 3rd rise; running=1.
- Preload by running to 59:58, then 2 rises -> 59:59 then 00:00; rollover=1 for exactly one cycle; HEX3..0 all "0".
- Pause after 00:05, apply 4 rises, resume, apply 1 rise -> displays 00:06.
- clear and start_stop in the same cycle during RUN at 00:12 -> state IDLE, 00:00, running=0 next cycle.
- LAP_EN: lap at 00:07, 5 rises -> display holds 00:07; second lap -> shows 00:12.
